input_debouncer: RTL and testbench

Conditioning stage that sits directly upstream of the top-level logic input `A` and drives it. It receives a raw, asynchronous, possibly bouncing level `din`. It synchronizes `din` into the `clk` domain, debounces it, and drives a clean level `dout`. It also produces single-cycle `rise`/`fall` event pulses and a rising-edge event counter for debug.

---
 rtl/input_debouncer_if.sv | 33 +++
 rtl/input_debouncer.sv | 159 +++++++++++++++
 tb/tb_input_debouncer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// Signal bundle between the debouncer and its consumer: raw level and count clear in,
// the clean level, edge events, pending flag and rise count out.
interface input_debouncer_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   din;
    logic                   clr_count;
    logic                   dout;
    logic                   rise;
    logic                   fall;
    logic                   busy;
    logic [COUNT_WIDTH-1:0] toggle_count;

    modport master (
        output din,
        output clr_count,
        input  dout,
        input  rise,
        input  fall,
        input  busy,
        input  toggle_count
    );

    modport slave (
        input  din,
        input  clr_count,
        output dout,
        output rise,
        output fall,
        output busy,
        output toggle_count
    );
endinterface

// File: rtl/input_debouncer.sv
// Synchronizes and debounces a raw asynchronous level into a clean registered level,
// with single-cycle rise/fall pulses and a wrapping rise counter.
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_WIDTH     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input_debouncer_if.slave   bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]       CNT_ONE   = CNT_W'(1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("input_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("input_debouncer: SYNC_STAGES must be at least 2");
    end

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   dout_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   busy_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] count_d;
    logic                   rise_evt_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // The FSM completes a low-to-high change on exactly this condition.
    assign rise_evt_s = (state_q == PEND_HIGH) && sync_s && (cnt_q == CNT_LAST);

    // Metastability shift chain; only its last stage is ever observed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.din};
        end
    end

    // Debounce FSM with registered level, event pulses and pending flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                STABLE_LOW: begin
                    if (sync_s) begin
                        state_q <= PEND_HIGH;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                PEND_HIGH: begin
                    if (!sync_s) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                        dout_q  <= 1'b1;
                        rise_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!sync_s) begin
                        state_q <= PEND_LOW;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                PEND_LOW: begin
                    if (sync_s) begin
                        state_q <= STABLE_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LOW;
                        cnt_q   <= '0;
                        dout_q  <= 1'b0;
                        fall_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= STABLE_LOW;
                    cnt_q   <= '0;
                    dout_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Clear takes effect before a coincident rise is counted.
    always_comb begin
        count_d = count_q;
        if (bus.clr_count) begin
            count_d = '0;
        end else begin
            count_d = count_q;
        end
        if (rise_evt_s) begin
            count_d = count_d + COUNT_ONE;
        end else begin
            count_d = count_d;
        end
    end

    // Rise counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rise         = rise_q;
    assign bus.fall         = fall_q;
    assign bus.busy         = busy_q;
    assign bus.toggle_count = count_q;
endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, COUNT_WIDTH=2.
module tb_input_debouncer;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    logic [1:0] exp_cnt;

    input_debouncer_if #(.COUNT_WIDTH(2)) ifc ();

    input_debouncer #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .COUNT_WIDTH    (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then park on the falling edge where outputs are stable.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int d, input int r, input int f, input int b);
        check_value({tag, " dout"}, int'(ifc.dout), d);
        check_value({tag, " rise"}, int'(ifc.rise), r);
        check_value({tag, " fall"}, int'(ifc.fall), f);
        check_value({tag, " busy"}, int'(ifc.busy), b);
        check_value({tag, " count"}, int'(ifc.toggle_count), int'(exp_cnt));
    endtask

    // Apply a new held level and follow the 6-edge debounce, plus one trailing edge.
    task automatic settle(input string name, input logic lvl, input bit chk_early, input bit clr_on_done);
        int d;
        int b;
        ifc.din = lvl;
        for (int e = 1; e <= 7; e++) begin
            if (e == 6 && clr_on_done) ifc.clr_count = 1'b1;
            tick();
            ifc.clr_count = 1'b0;
            if (e == 6 && lvl) exp_cnt = clr_on_done ? 2'd1 : exp_cnt + 2'd1;
            d = (e >= 6) ? int'(lvl) : int'(!lvl);
            b = (e >= 3 && e <= 5) ? 1 : 0;
            check_value($sformatf("%s e%0d dout", name, e), int'(ifc.dout), d);
            check_value($sformatf("%s e%0d rise", name, e), int'(ifc.rise), (e == 6 && lvl) ? 1 : 0);
            check_value($sformatf("%s e%0d fall", name, e), int'(ifc.fall), (e == 6 && !lvl) ? 1 : 0);
            if (!chk_early || e >= 3)
                check_value($sformatf("%s e%0d busy", name, e), int'(ifc.busy), b);
            check_value($sformatf("%s e%0d count", name, e), int'(ifc.toggle_count), int'(exp_cnt));
        end
    endtask

    initial begin
        int bounce_din [5];
        int bounce_busy[5];
        int glitch_busy[8];
        n_vec   = 0;
        n_miss  = 0;
        exp_cnt = 2'd0;
        bounce_din  = '{1, 0, 1, 1, 0};
        bounce_busy = '{0, 0, 1, 0, 1};
        glitch_busy = '{0, 0, 1, 1, 1, 0, 0, 0};

        // Reset held with din high: everything stays zero.
        rst           = 1'b1;
        ifc.din       = 1'b1;
        ifc.clr_count = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("rst%0d", i), 0, 0, 0, 0);
        end
        rst = 1'b0;
        settle("rel", 1'b1, 1'b0, 1'b0);

        // Clean steps in both directions.
        settle("step_lo", 1'b0, 1'b0, 1'b0);
        settle("step_hi", 1'b1, 1'b0, 1'b0);
        settle("step_lo2", 1'b0, 1'b0, 1'b0);

        // Bouncing input: the FSM restarts, only the final hold produces a rise.
        for (int i = 0; i < 5; i++) begin
            ifc.din = bounce_din[i][0];
            tick();
            check_all($sformatf("bounce%0d", i), 0, 0, 0, bounce_busy[i]);
        end
        settle("bounce_hold", 1'b1, 1'b1, 1'b0);

        // Three-cycle low glitch while high: rejected, busy pulses.
        for (int i = 0; i < 8; i++) begin
            ifc.din = (i < 3) ? 1'b0 : 1'b1;
            tick();
            check_all($sformatf("glitch%0d", i), 1, 0, 0, glitch_busy[i]);
        end

        // Counter wraps 3 -> 0, then counts up again.
        settle("wrap_lo", 1'b0, 1'b0, 1'b0);
        settle("wrap_hi", 1'b1, 1'b0, 1'b0);
        settle("cnt_lo", 1'b0, 1'b0, 1'b0);
        settle("cnt_hi", 1'b1, 1'b0, 1'b0);

        // Clear coinciding with a rise yields 1, not 2.
        settle("clr_lo", 1'b0, 1'b0, 1'b0);
        settle("clr_hi", 1'b1, 1'b0, 1'b1);

        // Standalone clear while idle.
        ifc.clr_count = 1'b1;
        exp_cnt       = 2'd0;
        tick();
        ifc.clr_count = 1'b0;
        check_all("clr_idle", 1, 0, 0, 0);

        // Reset in the middle of a pending rise abandons it.
        settle("mid_lo", 1'b0, 1'b0, 1'b0);
        ifc.din = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_all("mid_pend", 0, 0, 0, 1);
        rst     = 1'b1;
        ifc.din = 1'b0;
        exp_cnt = 2'd0;
        tick();
        check_all("mid_rst", 0, 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_all($sformatf("post_rst%0d", i), 0, 0, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
